// File: rtl/frame_stack_pkg.sv
// frame_stack_pkg: shared encodings for the frame-aware operand stack.
//   - op codes presented on frame_stack.op_i
//   - status codes reported on frame_stack.status_o
//   - FSM state encodings of the RETURN copy / local zeroing sequencer
package frame_stack_pkg;

    localparam logic [2:0] OpNop      = 3'd0;
    localparam logic [2:0] OpPush     = 3'd1;
    localparam logic [2:0] OpPop      = 3'd2;
    localparam logic [2:0] OpReplace  = 3'd3;
    localparam logic [2:0] OpLocalGet = 3'd4;
    localparam logic [2:0] OpLocalSet = 3'd5;
    localparam logic [2:0] OpCall     = 3'd6;
    localparam logic [2:0] OpReturn   = 3'd7;

    localparam logic [2:0] StatNone           = 3'd0;
    localparam logic [2:0] StatEmpty          = 3'd1;
    localparam logic [2:0] StatFull           = 3'd2;
    localparam logic [2:0] StatUnderflow      = 3'd3;
    localparam logic [2:0] StatOverflow       = 3'd4;
    localparam logic [2:0] StatBadOffset      = 3'd5;
    localparam logic [2:0] StatFrameOverflow  = 3'd6;
    localparam logic [2:0] StatFrameUnderflow = 3'd7;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCopy = 2'd1;
    localparam logic [1:0] StZero = 2'd2;

endpackage

// File: rtl/frame_ptr_stack.sv
// frame_ptr_stack: LIFO of saved frame base pointers.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (clears depth only)
//   push_i         push data_i (ignored when full)
//   pop_i          drop the top entry (ignored when empty)
//   data_i         base pointer to save
//   top_o          most recently saved base (undefined when empty)
//   full_o         2^FRAMES entries held
//   empty_o        no entries held
//   depth_o        number of entries held
module frame_ptr_stack #(
    parameter int unsigned AW     = 8,
    parameter int unsigned FRAMES = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [AW-1:0]   data_i,
    output logic [AW-1:0]   top_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [FRAMES:0] depth_o
);

    localparam int unsigned DW = FRAMES + 1;
    localparam logic [DW-1:0] Cap = DW'(2 ** FRAMES);
    localparam logic [DW-1:0] One = DW'(1);

    logic [AW-1:0] mem_q [2 ** FRAMES];
    logic [DW-1:0] depth_q;

    assign full_o  = (depth_q == Cap);
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;
    assign top_o   = mem_q[FRAMES'(depth_q - One)];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth_q <= '0;
        end else if (push_i && !full_o) begin
            depth_q <= depth_q + One;
        end else if (pop_i && !empty_o) begin
            depth_q <= depth_q - One;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[FRAMES'(depth_q)] <= data_i;
        end
    end

endmodule

// File: rtl/frame_stack.sv
// frame_stack: operand stack with call-frame awareness for the Wasm core.
// Underflow is checked against the current frame base; a LIFO of saved bases
// tracks nested calls. RETURN copies results down to the frame base over
// several cycles with ready_o low.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   op_i                operation code (frame_stack_pkg Op*), sampled when ready_o
//   data_i              value for PUSH/REPLACE
//   offset_i            local slot relative to frame base
//   count_i             pop count / CALL argument count / RETURN result count
//   ready_o             a new op is sampled on the next edge
//   index_o             number of entries on the stack
//   frame_base_o        base of the current frame
//   frame_depth_o       number of saved frames
//   out_o               registered top of stack (or LOCAL_GET result)
//   out1_o, out2_o      combinational stack[index-2], stack[index-3]
//   status_o            result of the last op (frame_stack_pkg Stat*)
// Build option: FRAME_STACK_ZERO_LOCALS_EN makes CALL reserve offset_i zeroed
// local slots above the arguments, one per cycle with ready_o low.
module frame_stack
    import frame_stack_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 7,
    parameter int unsigned FRAMES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [DEPTH:0]   offset_i,
    input  logic [DEPTH:0]   count_i,
    output logic             ready_o,
    output logic [DEPTH:0]   index_o,
    output logic [DEPTH:0]   frame_base_o,
    output logic [FRAMES:0]  frame_depth_o,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] out1_o,
    output logic [WIDTH-1:0] out2_o,
    output logic [2:0]       status_o
);

    localparam int unsigned IW = DEPTH + 1;
    localparam logic [IW-1:0] Cap = IW'(2 ** DEPTH);
    localparam logic [IW-1:0] One = IW'(1);

    logic [WIDTH-1:0] mem_q [2 ** DEPTH];
    logic [IW-1:0]    index_q, index_d, base_q, base_d;
    logic [IW-1:0]    src_q, src_d, dst_q, dst_d, rem_q, rem_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [2:0]       status_q, status_d;
    logic [1:0]       state_q, state_d;

    logic             mem_we;
    logic [DEPTH-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             fp_push, fp_pop, fp_full, fp_empty;
    logic [IW-1:0]    fp_top;
    logic             done;

    logic [IW-1:0]    live, ret_src;
    logic [DEPTH-1:0] tos_addr, local_addr, new_tos_addr;

    assign live       = index_q - base_q;
    assign ret_src    = index_q - count_i;
    assign tos_addr   = DEPTH'(index_q - One);
    assign local_addr = DEPTH'(base_q + offset_i);

    frame_ptr_stack #(
        .AW     (IW),
        .FRAMES (FRAMES)
    ) u_frames (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fp_push),
        .pop_i   (fp_pop),
        .data_i  (base_q),
        .top_o   (fp_top),
        .full_o  (fp_full),
        .empty_o (fp_empty),
        .depth_o (frame_depth_o)
    );

    always_comb begin
        index_d   = index_q;
        base_d    = base_q;
        out_d     = out_q;
        status_d  = status_q;
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        fp_push   = 1'b0;
        fp_pop    = 1'b0;
        done      = 1'b0;

        case (state_q)
            StIdle: begin
                unique case (op_i)
                    OpNop: done = 1'b1;
                    OpPush: begin
                        if (index_q == Cap) begin
                            status_d = StatOverflow;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = DEPTH'(index_q);
                            mem_wdata = data_i;
                            index_d   = index_q + One;
                            done      = 1'b1;
                        end
                    end
                    OpPop: begin
                        if (count_i > live) begin
                            status_d = StatUnderflow;
                        end else begin
                            index_d = index_q - count_i;
                            done    = 1'b1;
                        end
                    end
                    OpReplace: begin
                        if (live == '0) begin
                            status_d = StatUnderflow;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = tos_addr;
                            mem_wdata = data_i;
                            done      = 1'b1;
                        end
                    end
                    OpLocalGet: begin
                        if (offset_i >= live) begin
                            status_d = StatBadOffset;
                        end else if (index_q == Cap) begin
                            status_d = StatOverflow;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = DEPTH'(index_q);
                            mem_wdata = mem_q[local_addr];
                            index_d   = index_q + One;
                            done      = 1'b1;
                        end
                    end
                    OpLocalSet: begin
                        // live > 0 is established before live - 1 is formed
                        if (live == '0) begin
                            status_d = StatUnderflow;
                        end else if (offset_i >= live - One) begin
                            status_d = StatBadOffset;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = local_addr;
                            mem_wdata = mem_q[tos_addr];
                            index_d   = index_q - One;
                            done      = 1'b1;
                        end
                    end
                    OpCall: begin
                        if (count_i > live) begin
                            status_d = StatUnderflow;
                        end else if (fp_full) begin
                            status_d = StatFrameOverflow;
`ifdef FRAME_STACK_ZERO_LOCALS_EN
                        end else if (({1'b0, index_q} + {1'b0, offset_i}) > {1'b0, Cap}) begin
                            status_d = StatOverflow;
`endif
                        end else begin
                            fp_push = 1'b1;
                            base_d  = index_q - count_i;
`ifdef FRAME_STACK_ZERO_LOCALS_EN
                            if (offset_i != '0) begin
                                state_d = StZero;
                                rem_d   = offset_i;
                            end else begin
                                done = 1'b1;
                            end
`else
                            done    = 1'b1;
`endif
                        end
                    end
                    OpReturn: begin
                        if (fp_empty) begin
                            status_d = StatFrameUnderflow;
                        end else if (count_i > live) begin
                            status_d = StatUnderflow;
                        end else if (count_i == '0 || ret_src == base_q) begin
                            // results already sit at the base: no copy needed
                            index_d = base_q + count_i;
                            base_d  = fp_top;
                            fp_pop  = 1'b1;
                            done    = 1'b1;
                        end else begin
                            state_d = StCopy;
                            src_d   = ret_src;
                            dst_d   = base_q;
                            rem_d   = count_i;
                        end
                    end
                    default: ;
                endcase
            end
            StCopy: begin
                mem_we    = 1'b1;
                mem_waddr = DEPTH'(dst_q);
                mem_wdata = mem_q[DEPTH'(src_q)];
                src_d     = src_q + One;
                dst_d     = dst_q + One;
                rem_d     = rem_q - One;
                if (rem_q == One) begin
                    index_d = dst_q + One;
                    base_d  = fp_top;
                    fp_pop  = 1'b1;
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
`ifdef FRAME_STACK_ZERO_LOCALS_EN
            StZero: begin
                mem_we    = 1'b1;
                mem_waddr = DEPTH'(index_q);
                mem_wdata = '0;
                index_d   = index_q + One;
                rem_d     = rem_q - One;
                if (rem_q == One) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Completion: refresh status and TOS from the post-op state, forwarding
        // a write that lands on the new top in this same cycle.
        new_tos_addr = DEPTH'(index_d - One);
        if (done) begin
            if (index_d == Cap) begin
                status_d = StatFull;
            end else if (index_d == base_d) begin
                status_d = StatEmpty;
            end else begin
                status_d = StatNone;
            end
            if (index_d == '0) begin
                out_d = '0;
            end else if (mem_we && mem_waddr == new_tos_addr) begin
                out_d = mem_wdata;
            end else begin
                out_d = mem_q[new_tos_addr];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            index_q  <= '0;
            base_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            out_q    <= '0;
            status_q <= StatEmpty;
            state_q  <= StIdle;
        end else begin
            index_q  <= index_d;
            base_q   <= base_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            out_q    <= out_d;
            status_q <= status_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ready_o      = (state_q == StIdle);
    assign index_o      = index_q;
    assign frame_base_o = base_q;
    assign out_o        = out_q;
    assign status_o     = status_q;
    assign out1_o       = mem_q[DEPTH'(index_q - IW'(2))];
    assign out2_o       = mem_q[DEPTH'(index_q - IW'(3))];

endmodule

// File: tb/tb_frame_stack.sv
// tb_frame_stack: scoreboard bench for frame_stack. The driver queues the
// hand-computed result of each op; a monitor pops and compares whenever the
// DUT presents a completed op (ready high after acceptance).
module tb_frame_stack;

    localparam int CAP = 128;
    localparam int NFR = 16;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3;
    localparam logic [2:0] LGET = 3'd4, LSET = 3'd5, CALL = 3'd6, RET = 3'd7;
    localparam int S_NONE = 0, S_EMPTY = 1, S_FULL = 2, S_UNDER = 3;
    localparam int S_OVER = 4, S_BADOFF = 5, S_FOVER = 6, S_FUNDER = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] data = '0;
    logic [7:0]  offset = '0;
    logic [7:0]  count = '0;
    logic        ready;
    logic [7:0]  idx, base;
    logic [4:0]  fd;
    logic [31:0] out, out1, out2;
    logic [2:0]  st;

    typedef struct {
        string  nm;
        int     idx;
        int     base;
        int     fd;
        int     st;
        longint out;
        longint o1;
        longint o2;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nfail = 0;
    bit   trk = 1'b0;
    bit   acc_q = 1'b0;
    bit   pend = 1'b0;

    frame_stack dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .op_i          (op),
        .data_i        (data),
        .offset_i      (offset),
        .count_i       (count),
        .ready_o       (ready),
        .index_o       (idx),
        .frame_base_o  (base),
        .frame_depth_o (fd),
        .out_o         (out),
        .out1_o        (out1),
        .out2_o        (out2),
        .status_o      (st)
    );

    always #5 clk = ~clk;

    // An op is accepted on an edge where the DUT was ready and one was offered.
    always @(posedge clk) acc_q <= rst_n && ready && trk;

    // Monitor: compare once the accepted op has completed.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (acc_q) pend = 1'b1;
                if (pend && ready) begin
                    pend = 1'b0;
                    nvec++;
                    if (sb.size() == 0) begin
                        nfail++;
                        $display("FAIL unexpected_result: got index=%0d status=%0d, want no result",
                                 idx, st);
                    end else begin
                        e  = sb.pop_front();
                        ok = (int'(idx) == e.idx) && (int'(base) == e.base) &&
                             (int'(fd) == e.fd) && (int'(st) == e.st);
                        if (e.out >= 0 && longint'(out) != e.out) ok = 1'b0;
                        if (e.o1 >= 0 && longint'(out1) != e.o1) ok = 1'b0;
                        if (e.o2 >= 0 && longint'(out2) != e.o2) ok = 1'b0;
                        if (!ok) begin
                            nfail++;
                            $display({"FAIL %s: got index=%0d base=%0d frames=%0d status=%0d ",
                                      "out=%0d out1=%0d out2=%0d; want index=%0d base=%0d ",
                                      "frames=%0d status=%0d out=%0d out1=%0d out2=%0d (-1 = any)"},
                                     e.nm, idx, base, fd, st, out, out1, out2,
                                     e.idx, e.base, e.fd, e.st, e.out, e.o1, e.o2);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2ms, want completion");
        $fatal(1);
    end

    task automatic issue(input logic [2:0] opc, input logic [31:0] d, input int off,
                         input int cnt);
        bit got;
        got = 1'b0;
        @(negedge clk);
        op     = opc;
        data   = d;
        offset = 8'(off);
        count  = 8'(cnt);
        trk    = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (acc_q) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            nvec++;
            nfail++;
            $display("FAIL accept_timeout: op=%0d not accepted, ready=%0b; want accepted", opc,
                     ready);
        end
        trk = 1'b0;
        op  = NOP;
    endtask

    task automatic run(input string nm, input logic [2:0] opc, input logic [31:0] d,
                       input int off, input int cnt, input int e_idx, input int e_base,
                       input int e_fd, input int e_st, input longint e_out = -1,
                       input longint e_o1 = -1, input longint e_o2 = -1);
        exp_t e;
        e.nm   = nm;
        e.idx  = e_idx;
        e.base = e_base;
        e.fd   = e_fd;
        e.st   = e_st;
        e.out  = e_out;
        e.o1   = e_o1;
        e.o2   = e_o2;
        sb.push_back(e);
        issue(opc, d, off, cnt);
    endtask

    task automatic chk_reset(input string nm);
        nvec++;
        if (!(ready === 1'b1 && idx === 8'd0 && base === 8'd0 && fd === 5'd0 &&
              out === 32'd0 && st === 3'd1)) begin
            nfail++;
            $display({"FAIL %s: got ready=%0b index=%0d base=%0d frames=%0d out=%0d status=%0d; ",
                      "want ready=1 index=0 base=0 frames=0 out=0 status=1"},
                     nm, ready, idx, base, fd, out, st);
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset(nm);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int low;
        repeat (2) @(negedge clk);
        chk_reset("reset_state");
        #2 rst_n = 1'b1;

        // Basic push/pop and the combinational lookahead outputs
        run("push10", PUSH, 10, 0, 0, 1, 0, 0, S_NONE, 10);
        run("push20", PUSH, 20, 0, 0, 2, 0, 0, S_NONE, 20);
        run("push30", PUSH, 30, 0, 0, 3, 0, 0, S_NONE, 30, 20, 10);
        run("pop2", POP, 0, 0, 2, 1, 0, 0, S_NONE, 10);
        run("pop1_empty", POP, 0, 0, 1, 0, 0, 0, S_EMPTY);

        // Fill to capacity, then one more
        for (int i = 0; i < CAP; i++) begin
            run("fill", PUSH, 32'(100 + i), 0, 0, i + 1, 0, 0,
                (i == CAP - 1) ? S_FULL : S_NONE, 100 + i);
        end
        run("push_overflow", PUSH, 5, 0, 0, CAP, 0, 0, S_OVER, 100 + CAP - 1);

        // Frame-relative underflow and locals
        do_reset("reset_after_fill");
        run("push1", PUSH, 1, 0, 0, 1, 0, 0, S_NONE, 1);
        run("push2", PUSH, 2, 0, 0, 2, 0, 0, S_NONE, 2);
        run("push3", PUSH, 3, 0, 0, 3, 0, 0, S_NONE, 3);
        run("call2", CALL, 0, 0, 2, 3, 1, 1, S_NONE, 3);
        run("pop3_underflow", POP, 0, 0, 3, 3, 1, 1, S_UNDER, 3);
        run("lget2_bad", LGET, 0, 2, 0, 3, 1, 1, S_BADOFF, 3);
        run("lget1", LGET, 0, 1, 0, 4, 1, 1, S_NONE, 3);
        run("replace8", REPL, 8, 0, 0, 4, 1, 1, S_NONE, 8);
        run("lset0", LSET, 0, 0, 0, 3, 1, 1, S_NONE, 3, 8, 1);
        run("lset1_bad", LSET, 0, 1, 0, 3, 1, 1, S_BADOFF, 3);

        // Multi-cycle RETURN copying two results down to the base
        do_reset("reset_before_return");
        run("push7", PUSH, 7, 0, 0, 1, 0, 0, S_NONE, 7);
        run("push5", PUSH, 5, 0, 0, 2, 0, 0, S_NONE, 5);
        run("push6", PUSH, 6, 0, 0, 3, 0, 0, S_NONE, 6);
        run("push9", PUSH, 9, 0, 0, 4, 0, 0, S_NONE, 9);
        run("call3", CALL, 0, 0, 3, 4, 1, 1, S_NONE, 9);
        run("return2", RET, 0, 0, 2, 3, 0, 0, S_NONE, 9, 6, 7);
        low = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready) break;
            low++;
        end
        nvec++;
        if (low != 2) begin
            nfail++;
            $display("FAIL return2_ready_low: got %0d cycles, want 2", low);
        end

        // Frame LIFO limits
        run("return_funder", RET, 0, 0, 0, 3, 0, 0, S_FUNDER, 9);
        for (int i = 0; i < NFR; i++) begin
            run("call0", CALL, 0, 0, 0, 3, 3, i + 1, S_EMPTY, 9);
        end
        run("call_fover", CALL, 0, 0, 0, 3, 3, NFR, S_FOVER, 9);
        run("return0", RET, 0, 0, 0, 3, 3, NFR - 1, S_EMPTY, 9);

        // Reset while a RETURN copy is in flight
        do_reset("reset_before_abort");
        run("push1b", PUSH, 1, 0, 0, 1, 0, 0, S_NONE, 1);
        run("push2b", PUSH, 2, 0, 0, 2, 0, 0, S_NONE, 2);
        run("push3b", PUSH, 3, 0, 0, 3, 0, 0, S_NONE, 3);
        run("push4b", PUSH, 4, 0, 0, 4, 0, 0, S_NONE, 4);
        run("call1", CALL, 0, 0, 1, 4, 3, 1, S_NONE, 4);
        run("push5b", PUSH, 5, 0, 0, 5, 3, 1, S_NONE, 5);
        run("push6b", PUSH, 6, 0, 0, 6, 3, 1, S_NONE, 6);
        run("push7b", PUSH, 7, 0, 0, 7, 3, 1, S_NONE, 7);
        issue(RET, 0, 0, 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("reset_mid_copy");
        @(negedge clk);
        #2 rst_n = 1'b1;
        run("push42", PUSH, 42, 0, 0, 1, 0, 0, S_NONE, 42);

        repeat (4) @(negedge clk);
        nvec++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL scoreboard_drain: got %0d pending results, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
